// File: rtl/sv_compactor_pkg.sv
// Shared types, default constants and the bus-folding helper for the
// output signature compactor.
package sv_compactor_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'h00000001;

    // Upper bounds for fold_xor; callers zero-extend into these widths.
    localparam int FOLD_MAX_IN   = 1024;
    localparam int FOLD_MAX_SIG  = 256;
    localparam int FOLD_IN_IDX_W = $clog2(FOLD_MAX_IN);
    localparam int FOLD_SIG_IDX_W = $clog2(FOLD_MAX_SIG);

    // Bit i of data lands in bit (i mod sig_width) of the result, which is the
    // XOR of all zero-padded sig_width-wide chunks.
    function automatic logic [FOLD_MAX_SIG-1:0] fold_xor(
        input logic [FOLD_MAX_IN-1:0] data,
        input int                     in_width,
        input int                     sig_width
    );
        logic [FOLD_MAX_SIG-1:0]   acc;
        logic [FOLD_SIG_IDX_W-1:0] pos;
        acc = '0;
        pos = '0;
        for (int i = 0; i < FOLD_MAX_IN; i++) begin
            if (i < in_width) begin
                acc[pos] = acc[pos] ^ data[i[FOLD_IN_IDX_W-1:0]];
            end
            pos = (int'(pos) == sig_width - 1) ? '0 : pos + FOLD_SIG_IDX_W'(1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/signature_serializer.sv
// Shifts a captured signature out MSB first on a single pin; snapshots that
// arrive while a frame is in progress are dropped and flagged as overrun.
module signature_serializer
    import sv_compactor_pkg::*;
#(
    parameter int SIG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 snap_i,
    input  logic [SIG_WIDTH-1:0] data_i,
    output logic                 sig_out_o,
    output logic                 sig_frame_o,
    output logic                 overrun_o
);

    localparam int              BC_W     = $clog2(SIG_WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SIG_WIDTH - 1);

    ser_state_t           state_q, state_d;
    logic [SIG_WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 overrun_q, overrun_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (snap_i) begin
                    shift_d   = data_i;
                    bit_cnt_d = LAST_BIT;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end
                if (snap_i) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    // Decoded from state so an asynchronous reset silences the pin at once.
    assign sig_frame_o = (state_q == SHIFT);
    assign sig_out_o   = sig_frame_o & shift_q[SIG_WIDTH-1];
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/output_signature_compactor.sv
// Folds a wide result bus into a MISR, snapshots the signature once per
// window of valid beats and hands it to the serial output.
module output_signature_compactor
    import sv_compactor_pkg::*;
#(
    parameter int                   IN_WIDTH  = 64,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY),
    parameter logic [SIG_WIDTH-1:0] SEED      = SIG_WIDTH'(DEFAULT_SEED),
    parameter int                   WINDOW    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic                          in_valid,
    output logic [SIG_WIDTH-1:0]          sig_parallel,
    output logic                          sig_valid,
    output logic                          sig_out,
    output logic                          sig_frame,
    output logic                          overrun,
    output logic [$clog2(WINDOW+1)-1:0]   window_count
);

    localparam int               CNT_W     = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    logic [SIG_WIDTH-1:0] folded;
    logic [SIG_WIDTH-1:0] misr_step;
    logic                 snapshot;

    logic [SIG_WIDTH-1:0] misr_q, misr_d;
    logic [SIG_WIDTH-1:0] sig_parallel_q, sig_parallel_d;
    logic                 sig_valid_q, sig_valid_d;
    logic [CNT_W-1:0]     window_count_q, window_count_d;

    assign folded    = SIG_WIDTH'(fold_xor(FOLD_MAX_IN'(in_data), IN_WIDTH, SIG_WIDTH));
    assign misr_step = {misr_q[SIG_WIDTH-2:0], 1'b0}
                     ^ (misr_q[SIG_WIDTH-1] ? POLY : '0)
                     ^ folded;
    assign snapshot  = in_valid && (window_count_q == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misr_q         <= SEED;
            sig_parallel_q <= '0;
            sig_valid_q    <= 1'b0;
            window_count_q <= '0;
        end else begin
            misr_q         <= misr_d;
            sig_parallel_q <= sig_parallel_d;
            sig_valid_q    <= sig_valid_d;
            window_count_q <= window_count_d;
        end
    end

    // The closing beat is folded into the snapshot, then the MISR restarts.
    always_comb begin
        misr_d         = misr_q;
        sig_parallel_d = sig_parallel_q;
        sig_valid_d    = 1'b0;
        window_count_d = window_count_q;
        if (in_valid) begin
            if (snapshot) begin
                misr_d         = SEED;
                sig_parallel_d = misr_step;
                sig_valid_d    = 1'b1;
                window_count_d = '0;
            end else begin
                misr_d         = misr_step;
                window_count_d = window_count_q + CNT_W'(1);
            end
        end
    end

    signature_serializer #(
        .SIG_WIDTH (SIG_WIDTH)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .snap_i      (snapshot),
        .data_i      (misr_step),
        .sig_out_o   (sig_out),
        .sig_frame_o (sig_frame),
        .overrun_o   (overrun)
    );

    assign sig_parallel = sig_parallel_q;
    assign sig_valid    = sig_valid_q;
    assign window_count = window_count_q;

endmodule

// File: doc/output_signature_compactor.md
Name: output_signature_compactor

Overview:
- Downstream consumer for a stereovision chip under test. It takes the chip's wide, otherwise-unobserved result buses, such as the 64-bit offchip SRAM data out, SRAM address and the bus_word outputs, concatenated into a single in_data vector.
- It compresses in_data into a multiple-input signature register (MISR). At the end of each observation window it snapshots the signature and shifts it out on one pin.
- This keeps all upstream logic live for synthesis and bitstream generation, and gives the lab a compact per-window checksum.

Parameters:
- IN_WIDTH, 64, width of in_data. Must be ≥ 1.
- SIG_WIDTH, 32, MISR width. Must be ≥ 2.
- POLY, 32'h04C11DB7, MISR feedback polynomial (x^SIG_WIDTH term implicit).
- SEED, 32'h00000001, nonzero value loaded into the MISR at reset and at each window restart.
- WINDOW, 1024, number of in_valid cycles per signature window. Must be ≥ 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  IN_WIDTH  result bus from the chip under test.
- in_valid  in  1  in_data is sampled this cycle.
- sig_parallel  out  SIG_WIDTH  last completed window signature.
- sig_valid  out  1  one-cycle pulse: sig_parallel was just updated.
- sig_out  out  1  serial signature bit, MSB first.
- sig_frame  out  1  high while sig_out carries a valid bit.
- overrun  out  1  sticky: a snapshot arrived while the serializer was busy.
- window_count  out  $clog2(WINDOW+1)  valid cycles accumulated in the current window.

Behaviour:
- Reset (async assert, sync release): misr=SEED; sig_parallel=0; sig_valid=0; sig_out=0; sig_frame=0; overrun=0; window_count=0; serializer state=IDLE.
- Fold: zero-pad in_data to a multiple of SIG_WIDTH, split it into SIG_WIDTH chunks, XOR the chunks together to form folded. Combinational.
- MISR update, only on in_valid=1:
  - next = {misr[SIG_WIDTH-2:0],1'b0} ^ (misr[SIG_WIDTH-1] ? POLY : 0) ^ folded.
  - With in_valid=0, the MISR and window_count hold.
- Window end: on an in_valid cycle with window_count==WINDOW-1, at the same edge:
  - sig_parallel ← next;
  - sig_valid ← 1 (for exactly one cycle);
  - misr ← SEED;
  - window_count ← 0.
  - The final beat's data is therefore included in the snapshot.
- Other in_valid cycles: window_count increments by 1.
- Serializer state machine, IDLE/SHIFT:
  - IDLE, snapshot edge: load shift register with next, set bit counter = SIG_WIDTH-1, go to SHIFT.
  - SHIFT: sig_frame=1 and sig_out=shift[SIG_WIDTH-1]. Shift left each cycle.
  - When the bit counter reaches 0, return to IDLE.
  - The frame lasts exactly SIG_WIDTH cycles, starting the cycle after the snapshot edge.
  - Snapshot arriving during SHIFT: sig_parallel and sig_valid still update; the serial frame continues with its old value (the new one is dropped); overrun ← 1.
  - A snapshot on the last SHIFT cycle also counts as overrun.
  - overrun clears only on reset.
- Reset asserted mid-frame: sig_frame and sig_out drop to 0 immediately.
- WINDOW ≥ SIG_WIDTH+1 guarantees no overrun under continuous in_valid.

Decomposition:
- Package sv_compactor_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - function fold_xor(data, IN_WIDTH, SIG_WIDTH), parameterised via a class-static or a width-generic loop;
  - localparam defaults for POLY and SEED.
- One natural sub-module, signature_serializer, containing the load/shift register, bit counter, state machine and overrun flag. The top level keeps the fold, the MISR and the window counter.

Test Plan (IN_WIDTH=16, SIG_WIDTH=8, POLY=8'h1D, SEED=8'h01, WINDOW=4 unless noted):
- Zero data: in_data=0, in_valid=1 for 4 cycles.
  - MISR steps 01→02→04→08→10.
  - sig_parallel=8'h10 with a single sig_valid pulse; window_count returns to 0.
- Fold: in_data=16'hA55A, one in_valid beat after reset.
  - folded=8'hFF; MISR=02^FF=8'hFD; window_count=1.
- Valid gaps: alternate in_valid 1/0 with in_data=0.
  - Snapshot 8'h10 after 8 cycles.
  - MISR and window_count unchanged on every in_valid=0 cycle.
- Serial output: after the 8'h10 snapshot, sig_frame is high for 8 cycles and sig_out reads 0,0,0,1,0,0,0,0.
  - overrun=0 when WINDOW=16.
- Overrun: WINDOW=4 with continuous in_valid.
  - The second snapshot lands during SHIFT, so overrun=1 and stays 1.
  - sig_parallel still updates; the serial frame carries the first signature.
- Async reset mid-frame: drive reset=0 during the 4th SHIFT bit.
  - sig_frame=0, sig_out=0 and misr=SEED without waiting for a clock edge.
  - After release, window_count=0.
